integrator_cell: RTL and testbench

Saturating fixed-point integrator cell element. It sits directly upstream of the output port stage and drives that stage's internal data/enable pair. On each input enable it scales the input sample by a programmable gain and adds the result to a running accumulator. All arithmetic is two's-complement with NUM_BITS_DECIMAL fractional bits. Every overflow is clipped to full scale, never wrapped.

---
 rtl/integrator_cell_if.sv | 24 ++
 rtl/integrator_cell.sv | 116 +++++++++++
 tb/tb_integrator_cell.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/integrator_cell_if.sv
// Sample/enable bus between the integrator cell and its neighbours:
// the upstream side drives samples and controls, the downstream side receives the accumulator value.
interface integrator_cell_if #(
    parameter int MSB = 31
);
    logic signed [MSB:0] in_data;
    logic                in_data_en;
    logic signed [MSB:0] gain;
    logic                clear;
    logic                hold;
    logic signed [MSB:0] out_data;
    logic                out_data_en;
    logic                sat;

    modport master (
        output in_data, in_data_en, gain, clear, hold,
        input  out_data, out_data_en, sat
    );

    modport slave (
        input  in_data, in_data_en, gain, clear, hold,
        output out_data, out_data_en, sat
    );
endinterface

// File: rtl/integrator_cell.sv
// Saturating fixed-point integrator: acc += clip(floor(in_data * gain)),
// computed in two pipeline stages. Every overflow clips to full scale.
module integrator_cell #(
    parameter int MSB              = 31,
    parameter int NUM_BITS_DECIMAL = 8
) (
    input  logic              clk,
    input  logic              rst,
    integrator_cell_if.slave  bus
);
    localparam int W  = MSB + 1;
    localparam int PW = 2 * W;

    localparam logic signed [W-1:0] MAX_V = {1'b0, {MSB{1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {MSB{1'b0}}};

    // Returns {clipped, value}; the value is in range when all bits above MSB match the sign.
    function automatic logic [W:0] sat_prod(input logic signed [PW-1:0] t);
        logic [W:0] r;
        if (&t[PW-1:MSB] || ~|t[PW-1:MSB]) r = {1'b0, t[MSB:0]};
        else if (t[PW-1])                  r = {1'b1, MIN_V};
        else                               r = {1'b1, MAX_V};
        return r;
    endfunction

    function automatic logic [W:0] sat_sum(input logic signed [W:0] s);
        logic [W:0] r;
        if (s[W] == s[W-1]) r = {1'b0, s[W-1:0]};
        else if (s[W])      r = {1'b1, MIN_V};
        else                r = {1'b1, MAX_V};
        return r;
    endfunction

    logic signed [PW-1:0] data_ext_p0, gain_ext_p0, prod_p0, shifted_p0;
    logic [W:0]           clip_p0;

    logic signed [W-1:0]  term_p1_q, term_p1_d;
    logic                 sat_p1_q,  sat_p1_d;
    logic                 vld_p1_q,  vld_p1_d;

    logic signed [W:0]    sum_p1;
    logic [W:0]           clip_p1;

    logic signed [W-1:0]  acc_q,      acc_d;
    logic signed [W-1:0]  out_data_q, out_data_d;
    logic                 out_en_q,   out_en_d;
    logic                 sat_q,      sat_d;

    // Stage 1: full-width product, floor shift, clip to data range
    always_comb begin
        data_ext_p0 = {{W{bus.in_data[MSB]}}, bus.in_data};
        gain_ext_p0 = {{W{bus.gain[MSB]}}, bus.gain};
        prod_p0     = data_ext_p0 * gain_ext_p0;
        shifted_p0  = prod_p0 >>> NUM_BITS_DECIMAL;
        clip_p0     = sat_prod(shifted_p0);

        vld_p1_d    = bus.in_data_en;
        term_p1_d   = term_p1_q;
        sat_p1_d    = sat_p1_q;
        if (bus.in_data_en) begin
            term_p1_d = clip_p0[W-1:0];
            sat_p1_d  = clip_p0[W];
        end
    end

    // Stage 2: accumulate with clear > hold priority
    always_comb begin
        sum_p1     = {acc_q[MSB], acc_q} + {term_p1_q[MSB], term_p1_q};
        clip_p1    = sat_sum(sum_p1);

        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_en_d   = 1'b0;
        sat_d      = 1'b0;

        if (bus.clear) begin
            acc_d      = '0;
            out_data_d = '0;
            out_en_d   = vld_p1_q;
        end else if (vld_p1_q) begin
            out_en_d = 1'b1;
            if (bus.hold) begin
                out_data_d = acc_q;
                sat_d      = sat_p1_q;
            end else begin
                acc_d      = clip_p1[W-1:0];
                out_data_d = clip_p1[W-1:0];
                sat_d      = sat_p1_q | clip_p1[W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            term_p1_q  <= '0;
            sat_p1_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_en_q   <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            term_p1_q  <= term_p1_d;
            sat_p1_q   <= sat_p1_d;
            vld_p1_q   <= vld_p1_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_data_en = out_en_q;
    assign bus.sat         = sat_q;
endmodule

// File: tb/tb_integrator_cell.sv
// Scoreboard bench for integrator_cell: a cycle-level arithmetic model queues expected
// outputs as stimulus is applied; a negedge monitor pops and compares each output strobe.
module tb_integrator_cell;
    localparam int MSB = 31;
    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINP = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    integrator_cell_if #(.MSB(MSB)) bus ();

    integrator_cell #(.MSB(MSB), .NUM_BITS_DECIMAL(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    // Reference model state: accumulator and the sample waiting for its accumulate cycle.
    longint acc_m  = 0;
    bit     pend_v = 1'b0;
    longint pend_t = 0;
    bit     pend_s = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic longint clip(input longint x, output bit c);
        c = 1'b0;
        if (x > MAXP) begin c = 1'b1; return MAXP; end
        if (x < MINP) begin c = 1'b1; return MINP; end
        return x;
    endfunction

    // floor(d*g / 256), clipped
    function automatic longint make_term(input logic [31:0] d, input logic [31:0] g, output bit c);
        longint p, q;
        p = longint'($signed(d)) * longint'($signed(g));
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return clip(q, c);
    endfunction

    task automatic step(input bit en, input logic [31:0] d, input logic [31:0] g,
                        input bit clr, input bit hld, input bit rs);
        longint s;
        bit     c;
        bus.in_data    = d;
        bus.gain       = g;
        bus.in_data_en = en;
        bus.clear      = clr;
        bus.hold       = hld;
        rst            = rs;
        if (rs) begin
            acc_m  = 0;
            pend_v = 1'b0;
        end else begin
            if (clr) begin
                acc_m = 0;
                if (pend_v) exp_q.push_back({1'b0, 32'h0});
            end else if (pend_v) begin
                if (hld) begin
                    exp_q.push_back({pend_s, acc_m[31:0]});
                end else begin
                    s     = clip(acc_m + pend_t, c);
                    acc_m = s;
                    exp_q.push_back({pend_s | c, s[31:0]});
                end
            end
            pend_v = en;
            if (en) pend_t = make_term(d, g, pend_s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic en1(input logic [31:0] d, input logic [31:0] g);
        step(1'b1, d, g, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.out_data_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_en: got data 0x%08h sat %0b with no expected entry",
                         bus.out_data, bus.sat);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", bus.out_data, e[31:0]);
                chk("sb_sat", {31'h0, bus.sat}, {31'h0, e[32]});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, g;
        int r;

        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_out_data", bus.out_data, 32'h0);
        chk("reset_out_en", {31'h0, bus.out_data_en}, 32'h0);
        chk("reset_sat", {31'h0, bus.sat}, 32'h0);

        // basic accumulation
        en1(32'h280, 32'h100); en1(32'h280, 32'h100); en1(32'h280, 32'h100);
        idle(2);
        chk("basic_acc", bus.out_data, 32'h780);

        // floor rounding
        do_clear();
        en1(32'hFFFF_FFFF, 32'h80); idle(2);
        chk("floor_neg", bus.out_data, 32'hFFFF_FFFF);
        en1(32'h1, 32'h80); idle(2);
        chk("floor_pos_zero", bus.out_data, 32'hFFFF_FFFF);

        // product saturation
        do_clear();
        en1(32'h7FFF_FFFF, 32'h7FFF_FFFF); idle(2);
        chk("prod_sat_pos", bus.out_data, 32'h7FFF_FFFF);
        do_clear();
        en1(32'h8000_0000, 32'h7FFF_FFFF); idle(2);
        chk("prod_sat_neg", bus.out_data, 32'h8000_0000);

        // accumulator saturation and recovery
        do_clear();
        en1(32'h7FFF_FF00, 32'h100); en1(32'h200, 32'h100); idle(2);
        chk("acc_sat", bus.out_data, 32'h7FFF_FFFF);
        en1(32'hFFFF_FF00, 32'h100); idle(2);
        chk("acc_recover", bus.out_data, 32'h7FFF_FEFF);

        // clear colliding with a stage-2 valid
        do_clear();
        en1(32'h100, 32'h100);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("clear_collide_data", bus.out_data, 32'h0);
        chk("clear_collide_en", {31'h0, bus.out_data_en}, 32'h1);
        idle(1);

        // hold during a valid term
        en1(32'h500, 32'h100); idle(1);
        en1(32'h100, 32'h100);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("hold_data", bus.out_data, 32'h500);
        chk("hold_en", {31'h0, bus.out_data_en}, 32'h1);
        idle(1);

        // clear and hold together on a valid: clear wins
        en1(32'h100, 32'h100);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("clear_over_hold", bus.out_data, 32'h0);
        idle(1);

        // reset mid-operation discards in-flight samples
        en1(32'h300, 32'h100); en1(32'h300, 32'h100);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("midrst_out_data", bus.out_data, 32'h0);
        en1(32'h300, 32'h100); idle(2);
        chk("post_rst_acc", bus.out_data, 32'h300);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) d = $urandom;
            else        d = 32'($signed($urandom_range(0, 32'h0020_0000)) - 32'sh0010_0000);
            r = int'($urandom_range(0, 99));
            if (r < 10) g = $urandom;
            else        g = 32'($signed($urandom_range(0, 32'h600)) - 32'sh300);
            step($urandom_range(0, 99) < 70, d, g,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 199) < 1);
        end
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outstanding expected outputs, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
